// File: rtl/pixel_dma_master_pkg.sv
// Shared definitions for the data-processor register interface and the
// pixel DMA master state machine.
package pixel_dma_master_pkg;

    localparam logic [31:0] DEF_CTRL_ADDR = 32'h0200_1000;
    localparam logic [31:0] DEF_DATA_ADDR = 32'h0200_100C;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_MODE_LSB  = 1;
    localparam int OUT_VALID_BIT  = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CTRL_ON  = 3'd1,
        S_POLL     = 3'd2,
        S_WRITE    = 3'd3,
        S_CTRL_OFF = 3'd4,
        S_ERR      = 3'd5
    } state_t;

    // Byte enables for a word holding 'filled' pixels; 0 means a full word.
    function automatic logic [3:0] lane_strb(input logic [1:0] filled);
        case (filled)
            2'd1:    return 4'h1;
            2'd2:    return 4'h3;
            2'd3:    return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/membus_xact.sv
// Single-transaction engine for the native memory bus: registered request,
// forced idle gap after every ack, and a wait-cycle timeout.
module membus_xact #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    assign ack     = mem_valid && mem_ready;
    assign rdata   = mem_rdata;
    // Fires on the wait cycle that would bring the count to TIMEOUT.
    assign timeout = mem_valid && !mem_ready && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            wait_cnt  <= '0;
        end else if (mem_valid) begin
            if (ack || timeout)
                mem_valid <= 1'b0;
            else
                wait_cnt <= wait_cnt + 1'b1;
        end else if (req) begin
            // Only launched from a low cycle, so every ack leaves a gap.
            mem_valid <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= wdata;
            mem_wstrb <= wstrb;
            wait_cnt  <= '0;
        end
    end

endmodule

// File: rtl/pixel_dma_master.sv
// Pixel DMA master: enables the data processor, polls pixels, packs them
// four per word into a RAM buffer, then disables the processor.
module pixel_dma_master
    import pixel_dma_master_pkg::*;
#(
    parameter logic [31:0] CTRL_ADDR = DEF_CTRL_ADDR,
    parameter logic [31:0] DATA_ADDR = DEF_DATA_ADDR,
    parameter int          TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [31:0] dst_base,
    input  logic [15:0] pixel_total,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] pixels_stored,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    state_t           state, state_nxt;
    logic [1:0]       mode_r;
    logic [31:0]      base_r;
    logic [15:0]      total_r;
    logic [15:0]      word_idx;
    logic [3:0][7:0]  pix_buf;
    logic [15:0]      pix_inc;
    logic [1:0]       lane;
    logic             pix_ok;

    logic        req, ack, timeout;
    logic [31:0] x_addr, x_wdata, rdata;
    logic [3:0]  x_wstrb;
    logic        unused_rdata;

    assign lane         = pixels_stored[1:0];
    assign pix_inc      = pixels_stored + 16'd1;
    assign pix_ok       = rdata[OUT_VALID_BIT];
    assign unused_rdata = ^rdata[31:9];

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        x_addr    = '0;
        x_wdata   = '0;
        x_wstrb   = '0;
        case (state)
            S_IDLE: if (start && pixel_total != 16'd0) state_nxt = S_CTRL_ON;
            S_CTRL_ON: begin
                req                           = 1'b1;
                x_addr                        = CTRL_ADDR;
                x_wdata[CTRL_START_BIT]       = 1'b1;
                x_wdata[CTRL_MODE_LSB +: 2]   = mode_r;
                x_wstrb                       = 4'hF;
                if (timeout)  state_nxt = S_ERR;
                else if (ack) state_nxt = S_POLL;
            end
            S_POLL: begin
                req    = 1'b1;
                x_addr = DATA_ADDR;
                if (timeout)
                    state_nxt = S_ERR;
                else if (ack && pix_ok && (lane == 2'd3 || pix_inc == total_r))
                    state_nxt = S_WRITE;
            end
            S_WRITE: begin
                req     = 1'b1;
                x_addr  = base_r + {14'b0, word_idx, 2'b00};
                x_wdata = pix_buf;
                x_wstrb = lane_strb(lane);
                if (timeout)  state_nxt = S_ERR;
                else if (ack) state_nxt = (pixels_stored == total_r) ? S_CTRL_OFF : S_POLL;
            end
            S_CTRL_OFF: begin
                req     = 1'b1;
                x_addr  = CTRL_ADDR;
                x_wstrb = 4'hF;
                if (timeout)  state_nxt = S_ERR;
                else if (ack) state_nxt = S_IDLE;
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            pixels_stored <= '0;
            pix_buf       <= '0;
            word_idx      <= '0;
            mode_r        <= '0;
            base_r        <= '0;
            total_r       <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE) && (state_nxt != S_ERR);
            if (timeout) error <= 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    done  <= pixel_total == 16'd0;
                    error <= 1'b0;
                    if (pixel_total != 16'd0) begin
                        mode_r        <= mode;
                        base_r        <= {dst_base[31:2], 2'b00};
                        total_r       <= pixel_total;
                        pixels_stored <= '0;
                        pix_buf       <= '0;
                        word_idx      <= '0;
                    end
                end
                S_POLL: if (ack && pix_ok) begin
                    pix_buf[lane] <= rdata[7:0];
                    pixels_stored <= pix_inc;
                end
                S_WRITE: if (ack) begin
                    word_idx <= word_idx + 16'd1;
                    pix_buf  <= '0;
                end
                S_CTRL_OFF: if (ack) done <= 1'b1;
                default: ;
            endcase
        end
    end

    membus_xact #(.TIMEOUT(TIMEOUT)) u_xact (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .addr      (x_addr),
        .wdata     (x_wdata),
        .wstrb     (x_wstrb),
        .ack       (ack),
        .rdata     (rdata),
        .timeout   (timeout),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

endmodule

// File: tb/tb_pixel_dma_master.sv
// Directed bench for pixel_dma_master: bus responder with write scoreboard
// and protocol checks, plus a linear sequence of runs and edge cases.
module tb_pixel_dma_master;

    localparam logic [31:0] CTRL_A = 32'h0200_1000;
    localparam logic [31:0] DATA_A = 32'h0200_100C;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] dst_base = 32'd0;
    logic [15:0] pixel_total = 16'd0;
    logic        busy, done, error;
    logic [15:0] pixels_stored;
    logic        mem_valid;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int total = 0;
    int bad = 0;

    wr_t         exp_q[$];
    logic [31:0] pix_q[$];

    int          max_dly = 0;
    bit          stall = 1'b0;
    int          dly = 0;
    bit          active = 1'b0;
    bit          acked = 1'b0;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    logic [3:0]  prev_wstrb = '0;

    pixel_dma_master #(.TIMEOUT(8)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .mode          (mode),
        .dst_base      (dst_base),
        .pixel_total   (pixel_total),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .pixels_stored (pixels_stored),
        .mem_valid     (mem_valid),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handles the transaction that will be acked at the coming posedge.
    task automatic service();
        wr_t e;
        if (mem_wstrb == 4'h0) begin
            chk("read_addr", 64'(mem_addr), 64'(DATA_A));
            mem_rdata = (pix_q.size() > 0) ? pix_q.pop_front() : 32'h0;
        end else begin
            mem_rdata = 32'h0;
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL wr_extra observed addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_addr_data", {mem_addr, mem_wdata}, {e.addr, e.data});
                chk("wr_strb", 64'(mem_wstrb), 64'(e.strb));
            end
        end
    endtask

    // Responder plus protocol checks, all on the falling edge.
    always @(negedge clk) begin
        if (acked) chk("idle_after_ack", 64'(mem_valid), 64'd0);
        if (prev_valid === 1'b1 && mem_valid === 1'b1 && !acked) begin
            chk("bus_stable", {mem_addr, mem_wdata}, {prev_addr, prev_wdata});
            chk("strb_stable", 64'(mem_wstrb), 64'(prev_wstrb));
        end
        acked = 1'b0;
        if (mem_valid !== 1'b1) begin
            mem_ready = 1'b0;
            active    = 1'b0;
        end else if (!active) begin
            active = 1'b1;
            dly    = int'($urandom_range(max_dly, 0));
        end
        if (active && !stall && !mem_ready) begin
            if (dly == 0) begin
                mem_ready = 1'b1;
                if (resetn) begin
                    acked = 1'b1;
                    service();
                end
            end else begin
                dly--;
            end
        end
        prev_valid = mem_valid;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_wstrb = mem_wstrb;
    end

    // Queue expected bus writes and the pixel stream for one run.
    // inv[i] inserts an invalid poll result before pixel i.
    task automatic plan(input logic [31:0] base, input logic [1:0] md, input int n,
                        input logic [7:0] first, input logic [15:0] inv);
        logic [31:0] word, base_al;
        logic [3:0]  strb;
        logic [7:0]  px;
        base_al = {base[31:2], 2'b00};
        exp_q.push_back('{CTRL_A, {29'b0, md, 1'b1}, 4'hF});
        word = '0;
        strb = '0;
        for (int i = 0; i < n; i++) begin
            px = first + 8'(i);
            if (i < 16 && inv[i]) pix_q.push_back({23'h1A5, 1'b0, 8'hEE});
            pix_q.push_back({23'h0B7, 1'b1, px});
            word[8*(i%4) +: 8] = px;
            strb[i%4] = 1'b1;
            if (i % 4 == 3 || i == n - 1) begin
                exp_q.push_back('{base_al + 32'(4 * (i / 4)), word, strb});
                word = '0;
                strb = '0;
            end
        end
        exp_q.push_back('{CTRL_A, 32'h0, 4'hF});
    endtask

    task automatic kick(input logic [31:0] base, input logic [1:0] md, input logic [15:0] n);
        dst_base    = base;
        mode        = md;
        pixel_total = n;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 3000) begin
            tick();
            c++;
        end
        chk("run_finished", 64'(busy), 64'd0);
    endtask

    task automatic post(input logic [15:0] n);
        chk("done_set", 64'(done), 64'd1);
        chk("no_error", 64'(error), 64'd0);
        chk("pixels_stored", 64'(pixels_stored), 64'(n));
        chk("all_writes_seen", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int  vc;
        bit  found;

        repeat (2) tick();
        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_flags", {61'd0, busy, done, error}, 64'd0);
        chk("rst_count", 64'(pixels_stored), 64'd0);
        resetn = 1'b1;
        tick();

        // nominal: 8 pixels, mode 2
        plan(32'h100, 2'd2, 8, 8'h10, 16'h0);
        kick(32'h100, 2'd2, 16'd8);
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_idle();
        post(16'd8);

        // tail word, unaligned base that wraps, and a start while busy
        plan(32'hFFFF_FFFE, 2'd1, 6, 8'hA0, 16'h0);
        kick(32'hFFFF_FFFE, 2'd1, 16'd6);
        repeat (5) tick();
        kick(32'h0000_0800, 2'd0, 16'd2);
        chk("busy_start_ignored", 64'(busy), 64'd1);
        wait_idle();
        post(16'd6);

        // invalid polls before pixels 1, 2 and 5
        plan(32'h200, 2'd0, 8, 8'h30, 16'h0026);
        kick(32'h200, 2'd0, 16'd8);
        wait_idle();
        post(16'd8);
        chk("invalid_polls_used", 64'(pix_q.size()), 64'd0);

        // random ack delay gives the same memory image
        max_dly = 5;
        plan(32'h100, 2'd2, 8, 8'h10, 16'h0);
        kick(32'h100, 2'd2, 16'd8);
        wait_idle();
        post(16'd8);
        plan(32'h280, 2'd3, 7, 8'hC0, 16'h0004);
        kick(32'h280, 2'd3, 16'd7);
        wait_idle();
        post(16'd7);
        max_dly = 0;

        // timeout during CTRL_ON
        stall = 1'b1;
        kick(32'h300, 2'd1, 16'd4);
        vc = 0;
        repeat (20) begin
            if (mem_valid) vc++;
            tick();
        end
        chk("timeout_valid_cycles", 64'(vc), 64'd8);
        chk("timeout_error", 64'(error), 64'd1);
        chk("timeout_busy", 64'(busy), 64'd0);
        chk("timeout_done", 64'(done), 64'd0);
        stall = 1'b0;

        // a new start clears error
        plan(32'h300, 2'd3, 4, 8'h60, 16'h0);
        kick(32'h300, 2'd3, 16'd4);
        chk("error_cleared", 64'(error), 64'd0);
        wait_idle();
        post(16'd4);

        // reset while the data write is outstanding
        plan(32'h400, 2'd1, 4, 8'h50, 16'h0);
        kick(32'h400, 2'd1, 16'd4);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (mem_valid && mem_wstrb == 4'hF && mem_addr == 32'h400) found = 1'b1;
            else tick();
        end
        chk("rst_write_seen", 64'(found), 64'd1);
        resetn = 1'b0;
        tick();
        chk("midrst_valid", 64'(mem_valid), 64'd0);
        chk("midrst_bus", {mem_addr, mem_wdata}, 64'd0);
        chk("midrst_wstrb", 64'(mem_wstrb), 64'd0);
        chk("midrst_flags", {61'd0, busy, done, error}, 64'd0);
        chk("midrst_count", 64'(pixels_stored), 64'd0);
        exp_q.delete();
        pix_q.delete();
        resetn = 1'b1;
        tick();

        // zero-length request: done with no bus traffic
        kick(32'h500, 2'd0, 16'd0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        vc = 0;
        repeat (6) begin
            if (mem_valid) vc++;
            tick();
        end
        chk("zero_no_bus", 64'(vc), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_dma_master.md
# pixel_dma_master

Bus initiator for the `rvsoc` native memory bus (`mem_valid`/`mem_ready`/`mem_addr`/`mem_wdata`/`mem_wstrb`/`mem_rdata`). It is the requesting end of the data-processor register interface. On a start pulse it:

- writes the processor CONTROL register to enable it,
- polls OUTPUT_DATA,
- packs each valid pixel into 32-bit words and writes them to a RAM buffer,
- disables the processor once the requested pixel count is stored.

It removes CPU polling from the pixel path and sits on a bus-arbiter master port next to the CPU.

## Interface
Parameters:
- CTRL_ADDR, 32'h0200_1000, processor CONTROL register address
- DATA_ADDR, 32'h0200_100C, processor OUTPUT_DATA register address
- TIMEOUT, 64, max cycles one transaction may wait for `mem_ready` (≥2)

Ports:
- clk  in  1  system clock
- resetn  in  1  reset; synchronous, active-low
- start  in  1  one-cycle command pulse; ignored while busy
- mode  in  2  written to CONTROL[2:1] at run start
- dst_base  in  32  destination byte address; bits [1:0] ignored (treated as 0)
- pixel_total  in  16  pixels to transfer; sampled on start
- busy  out  1  run in progress
- done  out  1  sticky; set on normal completion, cleared by next accepted start
- error  out  1  sticky; set on timeout, cleared by next accepted start
- pixels_stored  out  16  pixels accepted so far in current or last run
- mem_valid  out  1  transaction request
- mem_addr  out  32  transaction address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte enables; 0 = read
- mem_ready  in  1  responder acknowledge
- mem_rdata  in  32  read data, valid while mem_ready=1

## Operation
States: IDLE, CTRL_ON, POLL, WRITE, CTRL_OFF, ERR.

- **IDLE**
  - On start with pixel_total≠0: latch inputs; clear done, error, pixels_stored, pack buffer and word index; go to CTRL_ON.
  - On start with pixel_total=0: set done; no bus traffic.
- **CTRL_ON**
  - Write CTRL_ADDR, wdata = {29'b0, mode, 1'b1}, wstrb=4'hF.
  - On ack, go to POLL.
- **POLL**
  - Read DATA_ADDR, wstrb=0.
  - On ack with rdata[8]=1: store rdata[7:0] into byte lane pixels_stored[1:0] (lane 0 = bits 7:0) and increment pixels_stored.
    - If the lane was 3, or the incremented count equals pixel_total, go to WRITE.
    - Otherwise issue the next POLL.
  - On ack with rdata[8]=0: discard and re-poll.
- **WRITE**
  - Address = dst_base + 4·word_idx; wdata = pack buffer; unfilled lanes are 0.
  - wstrb has one bit set per filled lane: full word 4'hF, tail of 1/2/3 pixels gives 4'h1/4'h3/4'h7.
  - On ack: increment word_idx and clear the buffer. If pixels_stored = pixel_total go to CTRL_OFF, else go to POLL.
- **CTRL_OFF**
  - Write CTRL_ADDR with 32'h0.
  - On ack: set done, go to IDLE.
- **ERR**
  - Entered from any bus state when the wait counter reaches TIMEOUT without ack.
  - Drop mem_valid; set error; busy=0.
  - Go to IDLE next cycle; no CTRL_OFF write is issued.
- **Address arithmetic:** 32-bit and wraps modulo 2^32.
- **busy:** 1 in every state except IDLE and ERR.

## Timing
- **Reset values:** mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0, done=0, error=0, pixels_stored=0; state IDLE.
- **Bus outputs:** all registered.
- **Request:** mem_valid rises the cycle after the state is entered. addr, wdata and wstrb are stable the whole time mem_valid=1.
- **Acknowledge:** sampled at the clock edge where mem_valid=1 and mem_ready=1. mem_valid is 0 the following cycle.
  - Every transaction is followed by at least one cycle with mem_valid=0, because the responder re-acks if valid stays high.
- **Single-cycle-ack responder:** each transaction occupies 3 cycles (valid, valid+ready, gap).
  - Best case per 4-pixel word: 4 polls + 1 write = 15 cycles.
- **Wait counter:** cleared when mem_valid rises; increments each cycle mem_valid=1 and mem_ready=0. ERR is entered when it reaches TIMEOUT.
- **mem_ready while mem_valid=0:** ignored.
- **start:** ignored while busy. start in the same cycle done would set: the run completes first and start is ignored.
- **Reset mid-transaction:** mem_valid is 0 the cycle after the reset edge; the partial word is lost.

## Structure
- Shared package/header `dataproc_defs.vh`:
  - default CTRL_ADDR and DATA_ADDR (also used by the processor wrapper),
  - CONTROL bit positions (start=0, mode=2:1),
  - OUTPUT_DATA valid bit (8),
  - state encodings.
- One sub-module `membus_xact` owns:
  - mem_valid, mem_addr, mem_wdata, mem_wstrb,
  - the idle gap,
  - the timeout counter.
  - Its interface is req/addr/wdata/wstrb in, ack/rdata/timeout out.
- The top holds the FSM, pack buffer, and counters.

## Test plan
- **Nominal run:** pixel_total=8, dst_base=0x100, mode=2, responder returns valid pixels 0x10..0x17.
  - One CONTROL write of 0x5.
  - Writes 0x13121110 to 0x100 and 0x17161514 to 0x104, both wstrb 4'hF.
  - CONTROL write of 0x0; done=1, pixels_stored=8.
- **Tail word:** pixel_total=6, pixels 0xA0..0xA5.
  - Second write is 0x0000A5A4 with wstrb 4'h3.
- **Invalid polls:** responder returns rdata[8]=0 on three polls between pixels.
  - Those reads are discarded; buffer contents and pixels_stored are unchanged.
- **Timeout:** TIMEOUT=8 and mem_ready held low during CTRL_ON.
  - mem_valid drops after 8 wait cycles; error=1, busy=0.
  - No further transactions; a new start clears error.
- **Protocol checker, all runs:** addr/wdata/wstrb stable while mem_valid=1; mem_valid=0 the cycle after each ack. Responder with a 0–5 cycle random ack delay gives identical memory contents.
- **Edges:**
  - pixel_total=0 sets done with no bus activity.
  - start while busy is ignored.
  - resetn low mid-WRITE gives mem_valid=0 and all outputs at reset values the next cycle.
